dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010000, byte address of data-memory word 0.
REQ-002 Parameter DEPTH_WORDS, default 2048, number of 32-bit words behind the arbiter.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive port-A wins allowed while port B waits.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 a_req  in  1  port A (CPU data side) request; held high until a_ack.
REQ-007 a_we  in  1  port A write (1) / read (0).
REQ-008 a_addr  in  32  port A byte address.
REQ-009 a_wdata  in  32  port A write data.
REQ-010 a_ack  out  1  port A one-cycle completion pulse.
REQ-011 a_rdata  out  32  port A read data, valid when a_ack is high.
REQ-012 a_err  out  1  port A access rejected, valid when a_ack is high.
REQ-013 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err: port B (loader/debug), same widths and meanings as port A.
REQ-014 mem_ena  out  1  to dram ena (read enable).
REQ-015 mem_wena  out  1  to dram wena.
REQ-016 mem_addr  out  32  to dram addr (byte address, passed unchanged).
REQ-017 mem_wdata  out  32  to dram data_in.
REQ-018 mem_rdata  in  32  from dram data_out (combinational read).

Function
REQ-019 FSM states: IDLE, ACCESS, RESP.
REQ-020 IDLE: if no req, stay; otherwise select a winner, latch its we/addr/wdata and port id, and validate the address.
REQ-021 Address is valid iff addr[1:0]==0 and BASE_ADDR <= addr <= BASE_ADDR + 4*DEPTH_WORDS - 4. The comparison is 32-bit unsigned.
REQ-022 Valid address: IDLE->ACCESS. Invalid address: IDLE->RESP with error flag set and no memory cycle.
REQ-023 ACCESS lasts exactly one cycle. In ACCESS, outputs are driven from the latched request: mem_ena=1, mem_wena=latched we, mem_addr=latched addr, mem_wdata=latched wdata.
REQ-024 ACCESS read: mem_rdata is captured into the response register at the posedge that ends ACCESS. ACCESS write: the dram commits at that same edge.
REQ-025 ACCESS->RESP unconditionally.
REQ-026 RESP lasts one cycle. The winner's ack=1, its rdata = captured data (0 for writes and errors), and its err = error flag. The other port's ack/err stay 0. RESP->IDLE.
REQ-027 Outside ACCESS: mem_ena=0, mem_wena=0, mem_addr=0, mem_wdata=0.
REQ-028 Outside RESP: a_ack, b_ack, a_err, b_err = 0 and a_rdata, b_rdata = 0.
REQ-029 Latency, valid access: req seen in IDLE at cycle 0 -> ack high in cycle 2. Invalid access: ack high in cycle 1.
REQ-030 Throughput: one valid access per 3 cycles.
REQ-031 A requester that keeps req high after its ack is treated as a new request at the next IDLE.
REQ-032 Arbitration: port A has priority when both request, unless the starvation counter equals STARVE_LIMIT, in which case B wins.
REQ-033 Starvation counter, 3 bits, saturating at STARVE_LIMIT:
- increments on each A grant made while b_req=1;
- clears on any B grant;
- clears in any IDLE cycle where b_req=0.
REQ-034 Requests arriving during ACCESS/RESP are not sampled until the next IDLE. Latched request fields are unaffected by input changes after the grant.

Reset
REQ-035 rst=1 at a posedge forces: state=IDLE, starvation counter=0, latched fields=0, and all outputs to their REQ-027/REQ-028 values from the next cycle.
REQ-036 mem_wena is gated by ~rst, so a reset asserted during ACCESS causes no dram write and no ack for the aborted access.

Verification
REQ-037 Single write/read: A writes 32'hDEADBEEF to 32'h10010004, then reads it. Required: the write ack comes in cycle 2 and the read ack in cycle 5 with a_rdata=32'hDEADBEEF, a_err=0.
REQ-038 Out-of-range: B reads 32'h10012000, then 32'h10010002. Required: each acked one cycle after sampling with b_err=1, b_rdata=0, and mem_ena never asserted.
REQ-039 Contention: a_req and b_req held high continuously with valid addresses. Required: grant order A,A,A,A,B,A,A,A,A,B,... and no lost or duplicated ack.
REQ-040 Boundary: A writes the last word 32'h10011FFC, then B reads it. Required: b_rdata equals the written value; 32'h10012000 is rejected.
REQ-041 Reset mid-access: rst asserted in the ACCESS cycle of a write of 32'h12345678 to 32'h10010010. Required: no ack, memory word unchanged, and all outputs 0 in the cycle after reset.
REQ-042 Input churn: a_addr and a_wdata change during ACCESS. Required: mem_addr and mem_wdata keep the values latched at grant.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of a single-ported data DRAM: port A has priority,
// port B is guaranteed a slot after STARVE_LIMIT consecutive A wins while it waits.
module dram_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h10010000,
    parameter int          DEPTH_WORDS  = 2048,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        a_req_i,
    input  logic        a_we_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    output logic        a_ack_o,
    output logic [31:0] a_rdata_o,
    output logic        a_err_o,

    input  logic        b_req_i,
    input  logic        b_we_i,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_ack_o,
    output logic [31:0] b_rdata_o,
    output logic        b_err_o,

    output logic        mem_ena_o,
    output logic        mem_wena_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [31:0] LAST_ADDR  = BASE_ADDR + 32'(DEPTH_WORDS * 4) - 32'd4;
    localparam logic [2:0]  STARVE_MAX = 3'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  starve_q, starve_d;

    logic        grant_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_valid;

    // B wins only when A is absent or B has waited through STARVE_LIMIT A grants.
    assign grant_b   = b_req_i && (!a_req_i || (starve_q == STARVE_MAX));
    assign sel_we    = grant_b ? b_we_i    : a_we_i;
    assign sel_addr  = grant_b ? b_addr_i  : a_addr_i;
    assign sel_wdata = grant_b ? b_wdata_i : a_wdata_i;
    assign sel_valid = (sel_addr[1:0] == 2'b00) &&
                       (sel_addr >= BASE_ADDR) && (sel_addr <= LAST_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (!b_req_i) begin
                    starve_d = '0;
                end
                if (a_req_i || b_req_i) begin
                    port_d  = grant_b;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = !sel_valid;
                    rdata_d = '0;
                    if (grant_b) begin
                        starve_d = '0;
                    end else if (b_req_i && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 3'd1;
                    end
                    state_d = sel_valid ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = mem_rdata_i;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The write strobe is masked by reset so an aborted access never commits.
    always_comb begin
        mem_ena_o   = 1'b0;
        mem_wena_o  = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        a_ack_o     = 1'b0;
        a_err_o     = 1'b0;
        a_rdata_o   = '0;
        b_ack_o     = 1'b0;
        b_err_o     = 1'b0;
        b_rdata_o   = '0;
        case (state_q)
            ACCESS: begin
                mem_ena_o   = 1'b1;
                mem_wena_o  = we_q & ~rst_i;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
            end
            RESP: begin
                if (port_q) begin
                    b_ack_o   = 1'b1;
                    b_err_o   = err_q;
                    b_rdata_o = rdata_q;
                end else begin
                    a_ack_o   = 1'b1;
                    a_err_o   = err_q;
                    a_rdata_o = rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a behavioural DRAM, a transaction-level reference model,
// directed scenarios for each corner case, then a randomized two-port phase.
module tb_dram_arbiter;

    localparam logic [31:0] BASE  = 32'h10010000;
    localparam int          DEPTH = 2048;
    localparam int          LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_ena, mem_wena;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dram_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack), .a_rdata_o(a_rdata), .a_err_o(a_err),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack), .b_rdata_o(b_rdata), .b_err_o(b_err),
        .mem_ena_o(mem_ena), .mem_wena_o(mem_wena), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DRAM: combinational read, write committed at the clock edge.
    logic [31:0] dram [DEPTH];
    logic        clearMem;

    function automatic bit addrValid(logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return (a[1:0] == 2'b00) && (ua >= longint'(BASE)) &&
               (ua <= longint'(BASE) + 4 * DEPTH - 4);
    endfunction

    function automatic int wordIdx(logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off) & (DEPTH - 1);
    endfunction

    always @(posedge clk) begin
        if (clearMem) begin
            for (int i = 0; i < DEPTH; i++) dram[i] <= 32'd0;
        end else if (mem_wena) begin
            dram[wordIdx(mem_addr)] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = 32'd0;
        if (addrValid(mem_addr)) mem_rdata = dram[wordIdx(mem_addr)];
    end

    // Reference model state: one transaction in flight, scheduled by latency rules.
    logic [31:0] refMem [DEPTH];
    bit          pend, pendB, pendWe, pendErr;
    logic [31:0] pendAddr, pendWdata, pendRdata;
    int          accessT, ackT, starve, cyc;
    int          checks, errors;

    bit          ackA, ackB, memEnaSeen;
    logic [31:0] lastRdA, lastRdB, lastMemAddr, lastMemWdata;
    bit          lastErrA, lastErrB;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, actual, expected);
        end
    endtask

    task automatic modelGrant();
        bit gb;
        logic [31:0] ad;
        if (!pend) begin
            if (!b_req) starve = 0;
            if (a_req || b_req) begin
                gb        = b_req && (!a_req || starve >= LIMIT);
                ad        = gb ? b_addr : a_addr;
                pend      = 1'b1;
                pendB     = gb;
                pendWe    = gb ? b_we : a_we;
                pendAddr  = ad;
                pendWdata = gb ? b_wdata : a_wdata;
                pendErr   = !addrValid(ad);
                pendRdata = 32'd0;
                accessT   = pendErr ? -1 : cyc + 1;
                ackT      = pendErr ? cyc + 1 : cyc + 2;
                if (gb) starve = 0;
                else if (b_req) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
            end
        end
    endtask

    // One clock cycle: predict, compare at the falling edge, retire, advance.
    task automatic stepCycle();
        bit inAccess, inResp, rA, rB;
        modelGrant();
        inAccess = pend && (cyc == accessT);
        inResp   = pend && (cyc == ackT);
        if (inAccess && !pendWe) pendRdata = refMem[wordIdx(pendAddr)];
        rA = inResp && !pendB;
        rB = inResp && pendB;
        @(negedge clk);
        checkOutput("mem_ena",   32'(mem_ena),  32'(inAccess));
        checkOutput("mem_wena",  32'(mem_wena), 32'(inAccess && pendWe && !rst));
        checkOutput("mem_addr",  mem_addr,  inAccess ? pendAddr  : 32'd0);
        checkOutput("mem_wdata", mem_wdata, inAccess ? pendWdata : 32'd0);
        checkOutput("a_ack",   32'(a_ack), 32'(rA));
        checkOutput("a_err",   32'(a_err), 32'(rA && pendErr));
        checkOutput("a_rdata", a_rdata, rA ? pendRdata : 32'd0);
        checkOutput("b_ack",   32'(b_ack), 32'(rB));
        checkOutput("b_err",   32'(b_err), 32'(rB && pendErr));
        checkOutput("b_rdata", b_rdata, rB ? pendRdata : 32'd0);
        ackA = a_ack; ackB = b_ack;
        lastRdA = a_rdata; lastRdB = b_rdata;
        lastErrA = a_err; lastErrB = b_err;
        lastMemAddr = mem_addr; lastMemWdata = mem_wdata;
        if (mem_ena) memEnaSeen = 1'b1;
        if (rst) begin
            pend   = 1'b0;
            starve = 0;
        end else begin
            if (inAccess && pendWe) refMem[wordIdx(pendAddr)] = pendWdata;
            if (inResp) pend = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic runUntilAck(input bit portB, input int budget, output int ackCyc);
        bit seen;
        seen   = 1'b0;
        ackCyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            stepCycle();
            if (portB ? ackB : ackA) begin
                seen   = 1'b1;
                ackCyc = cyc - 1;
            end
        end
        checkOutput(portB ? "b_ack_seen" : "a_ack_seen", 32'(seen), 32'd1);
    endtask

    task automatic applyStimulus(input bit portB, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if (portB) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
    endtask

    task automatic goIdle();
        a_req = 1'b0; b_req = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle();
    endtask

    function automatic logic [31:0] randAddr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 10) return BASE + 32'($urandom_range(0, 31) << 2);
        if (r < 13) return BASE + 32'($urandom_range(0, DEPTH - 1) << 2);
        if (r == 13) return BASE + 32'(4 * DEPTH);
        if (r == 14) return BASE - 32'd4;
        return BASE + 32'($urandom_range(0, 31) << 2) + 32'd2;
    endfunction

    task automatic driveRandom(input bit portB);
        bit req, acked;
        req   = portB ? b_req : a_req;
        acked = portB ? ackB : ackA;
        if (!req || acked) begin
            if ($urandom_range(0, 1) == 1)
                applyStimulus(portB, 1'($urandom_range(0, 1)), randAddr(), $urandom());
            else if (portB) b_req = 1'b0;
            else a_req = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            if (portB) begin b_addr = randAddr(); b_wdata = $urandom(); end
            else begin a_addr = randAddr(); a_wdata = $urandom(); end
        end
    endtask

    initial begin
        int c0, ackCyc, k;
        bit anyAck;
        checks = 0; errors = 0; cyc = 0; starve = 0; pend = 1'b0;
        ackA = 1'b0; ackB = 1'b0; memEnaSeen = 1'b0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = 32'd0;
        rst = 1'b1; clearMem = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
        @(posedge clk); #1;
        clearMem = 1'b0;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();

        // Write then read back on port A: acks at cycles 2 and 5.
        c0 = cyc;
        applyStimulus(1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF);
        runUntilAck(1'b0, 10, ackCyc);
        checkOutput("wr_latency", 32'(ackCyc - c0), 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h10010004, 32'd0);
        runUntilAck(1'b0, 10, ackCyc);
        checkOutput("rd_latency", 32'(ackCyc - c0), 32'd5);
        checkOutput("rd_data", lastRdA, 32'hDEADBEEF);
        checkOutput("rd_err", 32'(lastErrA), 32'd0);
        goIdle();

        // Port B rejections: past-the-end and misaligned, no memory cycle.
        memEnaSeen = 1'b0;
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 32'h10012000, 32'd0);
        runUntilAck(1'b1, 10, ackCyc);
        checkOutput("oor_latency", 32'(ackCyc - c0), 32'd1);
        checkOutput("oor_err", 32'(lastErrB), 32'd1);
        checkOutput("oor_rdata", lastRdB, 32'd0);
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 32'h10010002, 32'd0);
        runUntilAck(1'b1, 10, ackCyc);
        checkOutput("mis_latency", 32'(ackCyc - c0), 32'd1);
        checkOutput("mis_err", 32'(lastErrB), 32'd1);
        checkOutput("mis_rdata", lastRdB, 32'd0);
        checkOutput("no_mem_ena", 32'(memEnaSeen), 32'd0);
        goIdle();

        // Contention: both ports held high; expect A,A,A,A,B repeating.
        applyStimulus(1'b0, 1'b0, BASE + 32'h40, 32'd0);
        applyStimulus(1'b1, 1'b0, BASE + 32'h80, 32'd0);
        k = 0;
        for (int i = 0; i < 60; i++) begin
            stepCycle();
            if (ackA || ackB) begin
                checkOutput("grant_order", 32'(ackB), 32'((k % 5) == 4));
                k++;
            end
        end
        checkOutput("grant_count", 32'(k), 32'd20);
        goIdle();

        // Last word: written by A, read by B; one past it rejected.
        applyStimulus(1'b0, 1'b1, 32'h10011FFC, 32'hCAFEF00D);
        runUntilAck(1'b0, 10, ackCyc);
        a_req = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h10011FFC, 32'd0);
        runUntilAck(1'b1, 10, ackCyc);
        checkOutput("last_word", lastRdB, 32'hCAFEF00D);
        checkOutput("last_err", 32'(lastErrB), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h10012000, 32'd0);
        runUntilAck(1'b1, 10, ackCyc);
        checkOutput("past_end_err", 32'(lastErrB), 32'd1);
        goIdle();

        // Reset during the ACCESS cycle of a write must leave the word untouched.
        applyStimulus(1'b0, 1'b1, 32'h10010010, 32'hA5A5A5A5);
        runUntilAck(1'b0, 10, ackCyc);
        goIdle();
        applyStimulus(1'b0, 1'b1, 32'h10010010, 32'h12345678);
        stepCycle();
        anyAck = 1'b0;
        rst = 1'b1;
        a_req = 1'b0;
        stepCycle();
        anyAck = anyAck | ackA;
        rst = 1'b0;
        stepCycle();
        anyAck = anyAck | ackA;
        checkOutput("rst_no_ack", 32'(anyAck), 32'd0);
        checkOutput("rst_mem_addr", lastMemAddr, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h10010010, 32'd0);
        runUntilAck(1'b0, 10, ackCyc);
        checkOutput("rst_word_kept", lastRdA, 32'hA5A5A5A5);
        goIdle();

        // Request fields churn during ACCESS; the latched values stay on the bus.
        applyStimulus(1'b0, 1'b1, BASE + 32'h20, 32'h11111111);
        stepCycle();
        a_addr = BASE + 32'h30;
        a_wdata = 32'h22222222;
        stepCycle();
        checkOutput("churn_addr", lastMemAddr, BASE + 32'h20);
        checkOutput("churn_wdata", lastMemWdata, 32'h11111111);
        runUntilAck(1'b0, 10, ackCyc);
        applyStimulus(1'b0, 1'b0, BASE + 32'h20, 32'd0);
        runUntilAck(1'b0, 10, ackCyc);
        checkOutput("churn_readback", lastRdA, 32'h11111111);
        goIdle();

        // Randomized traffic on both ports with occasional resets.
        for (int i = 0; i < 600; i++) begin
            driveRandom(1'b0);
            driveRandom(1'b1);
            rst = ($urandom_range(0, 149) == 0);
            stepCycle();
        end
        rst = 1'b0;
        goIdle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
